// File: rtl/clk_switch_seq_if.sv
// rtl/clk_switch_seq_if.sv - request/ack, quiesce handshake and clock-select bundle for clk_switch_seq
interface clk_switch_seq_if #(
  parameter int CNT_W = 8
);
  logic             req;
  logic             req_sel;
  logic             ack;
  logic             err;
  logic             busy;
  logic             quiesce_req;
  logic             quiesce_ack;
  logic             sel;
  logic [CNT_W-1:0] sw_cnt;

  modport master (
    output req, req_sel, quiesce_ack,
    input  ack, err, busy, quiesce_req, sel, sw_cnt
  );

  modport slave (
    input  req, req_sel, quiesce_ack,
    output ack, err, busy, quiesce_req, sel, sw_cnt
  );
endinterface

// File: rtl/clk_switch_seq.sv
// rtl/clk_switch_seq.sv - quiesce/switch/settle/dwell sequencer driving a glitch-free clock mux select
// Optional quiesce-ack timeout abort: define CLK_SWITCH_SEQ_TIMEOUT_EN.
module clk_switch_seq #(
  parameter bit RESET_SEL  = 1'b0,
  parameter int SETTLE_CYC = 8,
  parameter int MIN_DWELL  = 16,
  parameter int TMO_CYC    = 64,
  parameter int CNT_W      = 8
) (
  input logic          clk,
  input logic          rst,
  clk_switch_seq_if.slave bus
);
  localparam int CMAX = (SETTLE_CYC > MIN_DWELL) ? SETTLE_CYC : MIN_DWELL;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, QUIESCE, SWITCH, RELEASE, DWELL} state_t;

  state_t           state;
  logic             sel_q;
  logic             tgt_q;
  logic             qreq_q;
  logic             ack_q;
  logic             busy_q;
  logic [CW-1:0]    dly_q;
  logic [CNT_W-1:0] cnt_q;

`ifdef CLK_SWITCH_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic          err_q;
  logic [TW-1:0] tmo_q;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.sel         = sel_q;
  assign bus.quiesce_req = qreq_q;
  assign bus.ack         = ack_q;
  assign bus.busy        = busy_q;
  assign bus.sw_cnt      = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel_q  <= RESET_SEL;
      tgt_q  <= RESET_SEL;
      qreq_q <= 1'b0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
      dly_q  <= '0;
      cnt_q  <= '0;
`ifdef CLK_SWITCH_SEQ_TIMEOUT_EN
      err_q  <= 1'b0;
      tmo_q  <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
`ifdef CLK_SWITCH_SEQ_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // ack_q gates sampling so the request being acked is not taken twice
          if (bus.req && !ack_q) begin
            if (bus.req_sel == sel_q) begin
              ack_q <= 1'b1;
            end else begin
              tgt_q  <= bus.req_sel;
              qreq_q <= 1'b1;
              busy_q <= 1'b1;
              state  <= QUIESCE;
`ifdef CLK_SWITCH_SEQ_TIMEOUT_EN
              tmo_q  <= '0;
`endif
            end
          end
        end
        QUIESCE: begin
          if (bus.quiesce_ack) begin
            sel_q <= tgt_q;
            dly_q <= CW'(SETTLE_CYC - 1);
            state <= SWITCH;
          end
`ifdef CLK_SWITCH_SEQ_TIMEOUT_EN
          else if (tmo_q == TW'(TMO_CYC - 1)) begin
            qreq_q <= 1'b0;
            ack_q  <= 1'b1;
            err_q  <= 1'b1;
            dly_q  <= CW'(MIN_DWELL - 1);
            state  <= DWELL;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        SWITCH: begin
          if (dly_q == '0) begin
            qreq_q <= 1'b0;
            state  <= RELEASE;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        RELEASE: begin
          if (!bus.quiesce_ack) begin
            ack_q <= 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            dly_q <= CW'(MIN_DWELL - 1);
            state <= DWELL;
          end
        end
        DWELL: begin
          if (dly_q == '0) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            dly_q <= dly_q - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_clk_switch_seq.sv
// tb/tb_clk_switch_seq.sv - scoreboard bench for clk_switch_seq: expected acks queued by stimulus, checked by monitor
module tb_clk_switch_seq;
  typedef struct {
    int   cyc;
    logic sel;
    logic err;
    int   cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic cons_en;
  logic d1, d2;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  clk_switch_seq_if #(.CNT_W(8)) bus();

  clk_switch_seq #(
    .RESET_SEL(1'b0), .SETTLE_CYC(8), .MIN_DWELL(16), .TMO_CYC(64), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic at_cyc(input int t);
    @(negedge clk);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drive_req(input logic r, input logic s);
    @(posedge clk);
    #1;
    bus.req     = r;
    bus.req_sel = s;
  endtask

  // Consumer answers quiesce_req with a two-cycle lag in both directions
  initial begin
    d1 = 1'b0;
    d2 = 1'b0;
    bus.quiesce_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cons_en) begin
        bus.quiesce_ack = d2;
        d2 = d1;
        d1 = bus.quiesce_req;
      end else begin
        bus.quiesce_ack = 1'b0;
        d1 = 1'b0;
        d2 = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("err_without_ack", int'(bus.err & ~bus.ack), 0);
      if (bus.ack) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ack: got ack=1 expected no ack at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack_cycle", cyc, e.cyc);
          check("ack_sel", int'(bus.sel), int'(e.sel));
          check("ack_err", int'(bus.err), int'(e.err));
          check("ack_sw_cnt", int'(bus.sw_cnt), e.cnt);
        end
      end
    end
  end

  // Timeline of one switch whose QUIESCE state is first visible at cycle q
  task automatic track(input int q, input logic old_s, input logic new_s);
    for (int c = q - 1; c <= q + 14; c++) begin
      at_cyc(c);
      check("busy", int'(bus.busy), (c >= q) ? 1 : 0);
      check("quiesce_req", int'(bus.quiesce_req), (c >= q && c <= q + 10) ? 1 : 0);
      check("sel", int'(bus.sel), int'((c >= q + 3) ? new_s : old_s));
    end
  endtask

  initial begin
    int d, q, a;
    rst = 1'b1;
    cons_en = 1'b1;
    bus.req = 1'b0;
    bus.req_sel = 1'b0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_sel", int'(bus.sel), 0);
    check("rst_quiesce_req", int'(bus.quiesce_req), 0);
    check("rst_ack", int'(bus.ack), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_sw_cnt", int'(bus.sw_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    drive_req(1'b1, 1'b0);
    d = cyc;
    exp_q.push_back('{cyc: d + 1, sel: 1'b0, err: 1'b0, cnt: 0});
    at_cyc(d + 1);
    check("noop_busy", int'(bus.busy), 0);
    drive_req(1'b0, 1'b0);
    at_cyc(d + 2);
    check("noop_busy_after", int'(bus.busy), 0);
    check("noop_sel_after", int'(bus.sel), 0);

    drive_req(1'b1, 1'b1);
    q = cyc + 1;
    exp_q.push_back('{cyc: q + 14, sel: 1'b1, err: 1'b0, cnt: 1});
    track(q, 1'b0, 1'b1);
    a = q + 14;

    drive_req(1'b1, 1'b0);
    exp_q.push_back('{cyc: a + 31, sel: 1'b0, err: 1'b0, cnt: 2});
    for (int c = a + 1; c <= a + 15; c++) begin
      at_cyc(c);
      check("dwell_busy", int'(bus.busy), 1);
      check("dwell_quiesce_req", int'(bus.quiesce_req), 0);
      check("dwell_sel", int'(bus.sel), 1);
    end
    track(a + 17, 1'b1, 1'b0);
    a = a + 31;

    drive_req(1'b1, 1'b1);
    q = a + 17;
    at_cyc(q + 5);
    check("pre_rst_sel", int'(bus.sel), 1);
    check("pre_rst_quiesce_req", int'(bus.quiesce_req), 1);
    rst = 1'b1;
    bus.req = 1'b0;
    at_cyc(q + 6);
    check("midrst_sel", int'(bus.sel), 0);
    check("midrst_quiesce_req", int'(bus.quiesce_req), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_ack", int'(bus.ack), 0);
    check("midrst_sw_cnt", int'(bus.sw_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cons_en = 1'b0;
    repeat (3) @(posedge clk);

    drive_req(1'b1, 1'b1);
    q = cyc + 1;
`ifdef CLK_SWITCH_SEQ_TIMEOUT_EN
    exp_q.push_back('{cyc: q + 64, sel: 1'b0, err: 1'b1, cnt: 0});
    at_cyc(q + 63);
    check("tmo_quiesce_req_before", int'(bus.quiesce_req), 1);
    at_cyc(q + 64);
    check("tmo_quiesce_req_after", int'(bus.quiesce_req), 0);
    check("tmo_busy", int'(bus.busy), 1);
`else
    for (int c = q; c < q + 200; c++) begin
      at_cyc(c);
      check("hang_busy", int'(bus.busy), 1);
    end
    check("hang_quiesce_req", int'(bus.quiesce_req), 1);
    check("hang_sel", int'(bus.sel), 0);
`endif
    drive_req(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("pending_acks", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end
endmodule
